bounded_updown_counter: RTL
===========================

Name: bounded_updown_counter

Overview:
- Parametrised successor to the team's fixed count-to-three counter.
- Counts up or down within the inclusive range [MIN_VAL, MAX_VAL]. Saturates or wraps at the bounds, selected per cycle.
- Supports synchronous clear and parallel load with range clamping, plus bound flags and a terminal-count pulse.
- Used wherever a small bounded index or retry counter is needed. The hard invariant is that out never leaves [MIN_VAL, MAX_VAL].

Parameters:
- WIDTH, 3: width of out and load_val.
- MIN_VAL, 0: lowest legal count value and the reset value of out.
- MAX_VAL, 3: highest legal count value.
- Elaboration error unless 0 <= MIN_VAL < MAX_VAL <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  reset. One clock; reset is synchronous and active-high (resetn==1 resets on the clk edge).
- clear  input  1  synchronous clear to MIN_VAL; also clears range_err.
- load  input  1  load load_val on this edge.
- load_val  input  WIDTH  value to load; clamped into range.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- wrap  input  1  bound mode: 1 = wrap to the opposite bound, 0 = saturate.
- out  output  WIDTH  registered count.
- at_max  output  1  combinational, out == MAX_VAL.
- at_min  output  1  combinational, out == MIN_VAL.
- tc  output  1  registered one-cycle pulse for a bound event.
- range_err  output  1  registered sticky flag for an out-of-range load.

Behaviour:
- All state updates on the rising clk edge. Priority per edge: resetn > clear > load > en. Lower-priority requests in the same cycle are ignored.
- Reset (resetn==1): out=MIN_VAL, tc=0, range_err=0. Applies regardless of any other input. Reset during a load or count discards that operation.
- Clear: out=MIN_VAL, tc=0, range_err=0.
- Load:
  - out = MIN_VAL if load_val < MIN_VAL; MAX_VAL if load_val > MAX_VAL; otherwise load_val.
  - range_err set to 1 if clamping occurred, otherwise it holds its value (sticky).
  - tc=0.
- Count (en==1, no higher-priority input):
  - up==1, out < MAX_VAL: out = out+1, tc=0.
  - up==1, out == MAX_VAL: out = MIN_VAL if wrap==1, else out stays MAX_VAL. tc=1 in both cases.
  - up==0, out > MIN_VAL: out = out-1, tc=0.
  - up==0, out == MIN_VAL: out = MAX_VAL if wrap==1, else out stays MIN_VAL. tc=1 in both cases.
- Idle (en==0, no clear/load/reset): out holds, tc=0, range_err holds.
- tc is high for exactly the one cycle following the bound-event edge. Repeated saturated counts at a bound give tc high on every such cycle.
- Arithmetic: comparisons are done before increment/decrement, so no intermediate overflow or underflow is ever registered.
  - When MAX_VAL == 2^WIDTH-1, the +1 is never taken at the bound.
  - When MIN_VAL == 0, the -1 is never taken at the bound.
- at_max/at_min are pure decodes of the registered out. They are never both 1, because MIN_VAL < MAX_VAL.
- No X propagation: out must be defined from the first edge where resetn==1.
- Assertion (verification): MIN_VAL <= out <= MAX_VAL on every cycle after reset.

Test Plan:
- Defaults (WIDTH=3, MIN=0, MAX=3), reset, then en=1, up=1, wrap=0 for 6 cycles -> out = 1,2,3,3,3,3; tc high on cycles 4,5,6; at_max high from cycle 3.
- Same parameters, wrap=1, up=1 from out=3 -> out=0 with tc=1 for one cycle. Then up=0 from out=0 -> out=3 with tc=1.
- WIDTH=4, MIN=2, MAX=10: load_val=15 -> out=10, range_err=1. Then load_val=5 -> out=5, range_err still 1. Then clear -> out=2, range_err=0.
- Simultaneous inputs: load=1 (load_val=1) with en=1, up=1 -> out=1, not incremented. Then clear=1 with load=1 -> out=MIN_VAL.
- Reset mid-count: out=2, en=1, resetn=1 -> out=0 and tc=0 on that edge. With resetn=0 and en=0 for 3 cycles, out holds at 0.
- Edge parameters WIDTH=2, MIN=0, MAX=3, saturate mode: decrement at 0 and increment at 3 -> out never changes past the bound, no wraparound through the 2-bit overflow, tc pulses each time.

Source files
------------

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter over [MIN_VAL, MAX_VAL].
// Saturates or wraps at the bounds; clamped load; sticky range error.
module bounded_updown_counter #(
    parameter int WIDTH   = 3,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             wrap,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             range_err
);

    // Reject bounds that are empty or do not fit in WIDTH bits.
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL &&
          MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_bad_bounds
        $error("bounded_updown_counter: illegal MIN_VAL/MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_nxt;
    logic             bound_hit;
    logic [WIDTH-1:0] ld_clamp;
    logic             ld_oor;

    // Next count value; the bound is tested before any +1/-1 so the
    // adder never overflows past the register width.
    always_comb begin
        bound_hit = up ? (out == MAXV) : (out == MINV);
        cnt_nxt   = out;
        if (bound_hit) begin
            if (wrap) begin
                cnt_nxt = up ? MINV : MAXV;
            end
        end else if (up) begin
            cnt_nxt = out + WIDTH'(1);
        end else begin
            cnt_nxt = out - WIDTH'(1);
        end
    end

    // Clamp the load value into range and flag whether it was clamped.
    always_comb begin
        ld_clamp = load_val;
        ld_oor   = 1'b0;
        if (load_val < MINV) begin
            ld_clamp = MINV;
            ld_oor   = 1'b1;
        end else if (load_val > MAXV) begin
            ld_clamp = MAXV;
            ld_oor   = 1'b1;
        end
    end

    // Count state: reset > clear > load > count > hold.
    always_ff @(posedge clk) begin
        if (resetn) begin
            out       <= MINV;
            tc        <= 1'b0;
            range_err <= 1'b0;
        end else if (clear) begin
            out       <= MINV;
            tc        <= 1'b0;
            range_err <= 1'b0;
        end else if (load) begin
            out       <= ld_clamp;
            tc        <= 1'b0;
            range_err <= range_err | ld_oor;
        end else if (en) begin
            out       <= cnt_nxt;
            tc        <= bound_hit;
        end else begin
            tc        <= 1'b0;
        end
    end

    assign at_max = (out == MAXV);
    assign at_min = (out == MINV);

endmodule
